// File: rtl/mem_uart_dump_pkg.sv
// Shared types and default sizing for the memory-to-UART dump block.
// Imported by the interface, the bit timer and the top level.
package mem_uart_dump_pkg;

    localparam int unsigned DefClksPerBit = 868;
    localparam int unsigned DefAddrW      = 6;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

endpackage

// File: rtl/mem_uart_dump_if.sv
// Command, RAM read port and serial output of the dump block, bundled for port lists.
// The slave modport is the dump block; the master side issues commands and owns the RAM.
interface mem_uart_dump_if
    import mem_uart_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
);

    logic              start;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output len,
        output rd_data,
        input  rd_addr,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  len,
        input  rd_data,
        output rd_addr,
        output tx,
        output busy,
        output done
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Baud counter for the UART transmitter: counts 0..CLKS_PER_BIT-1 while enabled and
// emits a one-cycle tick on the wrap. A clear forces the count back to zero.
module uart_tx_bit_timer
    import mem_uart_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_uart_dump.sv
// Streams bytes 0..len-1 of a block RAM out of an 8N1 UART line, LSB first.
// Sits beside the RAM's second read port; all outputs come straight from flops.
module mem_uart_dump
    import mem_uart_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned ADDR_W       = DefAddrW
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_uart_dump_if.slave bus
);

    localparam logic [ADDR_W:0] CountOne = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              armed_q;
    logic              tick;
    logic              timer_en;
    logic              timer_clr;

    assign timer_clr = (state_q == StLoad);
    assign timer_en  = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

    uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (timer_en),
        .clr_i (timer_clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_addr_d = rd_addr_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // armed_q keeps the first edge after reset release from accepting a start
                if (bus.start && armed_q) begin
                    if (bus.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        count_d   = bus.len;
                        rd_addr_d = '0;
                        state_d   = StFetch;
                    end
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                shift_d = bus.rd_data;
                state_d = StStart;
            end
            StStart: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    count_d = count_q - 1'b1;
                    if (count_q == CountOne) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = StFetch;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);

        // tx is computed from the next state so the line flop changes with the state
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            rd_addr_q <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            armed_q   <= 1'b1;
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_mem_uart_dump.sv
// Bench for mem_uart_dump: RAM model with 1-cycle read latency, a UART frame decoder,
// table-driven dump vectors and hand-written sequences for restart and mid-frame reset.
module tb_mem_uart_dump;

    localparam int Cpb      = 4;
    localparam int AW       = 6;
    localparam int FrameCyc = 10 * Cpb;
    localparam int Budget   = 4000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_uart_dump_if #(.ADDR_W(AW)) u_if ();

    mem_uart_dump #(
        .CLKS_PER_BIT(Cpb),
        .ADDR_W      (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    always @(posedge clk) u_if.rd_data <= mem[u_if.rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Frame decoder and event logs
    int          fpos = -1;
    logic [FrameCyc-1:0] fsamp;
    int          fstart;
    logic [AW-1:0] faddr;
    logic [7:0]  rx_bytes[$];
    int          rx_start[$];
    logic [AW-1:0] rx_addr[$];
    int shape_err, done_cnt, done_cyc, overlap_cnt, busy_seen, low_seen;

    task automatic decode_frame();
        logic [7:0] b;
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 10; k++)
            for (int j = 1; j < Cpb; j++)
                if (fsamp[k*Cpb+j] !== fsamp[k*Cpb]) bad = 1'b1;
        if (fsamp[0] !== 1'b0 || fsamp[9*Cpb] !== 1'b1) bad = 1'b1;
        for (int k = 0; k < 8; k++) b[k] = fsamp[(k+1)*Cpb];
        if (bad) shape_err++;
        rx_bytes.push_back(b);
        rx_start.push_back(fstart);
        rx_addr.push_back(faddr);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            fpos = -1;
        end else begin
            if (u_if.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (u_if.done === 1'b1 && u_if.busy === 1'b1) overlap_cnt++;
            if (u_if.busy !== 1'b0) busy_seen++;
            if (u_if.tx !== 1'b1) low_seen++;
            if (fpos < 0 && u_if.tx === 1'b0) begin
                fpos   = 0;
                fstart = cyc;
                faddr  = u_if.rd_addr;
            end
            if (fpos >= 0) begin
                fsamp[fpos] = u_if.tx;
                fpos++;
                if (fpos == FrameCyc) begin
                    decode_frame();
                    fpos = -1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rx_bytes.delete();
        rx_start.delete();
        rx_addr.delete();
        shape_err   = 0;
        done_cnt    = 0;
        done_cyc    = -1;
        overlap_cnt = 0;
        busy_seen   = 0;
        low_seen    = 0;
    endtask

    function automatic logic [7:0] fill_val(input int mode, input int i);
        case (mode)
            0:       fill_val = (i == 0) ? 8'h41 : 8'hFF;
            1:       fill_val = (i == 0) ? 8'h48 : (i == 1) ? 8'h49 : (i == 2) ? 8'h21 : 8'h00;
            default: fill_val = 8'(i);
        endcase
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < 64; i++) mem[i] = fill_val(mode, i);
    endtask

    // Returns the cycle number of the edge that samples start.
    task automatic pulse_start(input int n, output int edge_cyc);
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.len   = (AW+1)'(n);
        edge_cyc   = cyc + 1;
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < Budget && done_cnt == 0; i++) @(negedge clk);
        if (done_cnt == 0) check({name, " done timeout"}, 64'd0, 64'd1);
    endtask

    typedef struct {
        int            fill;
        int            len;
        int            n_frames;
        logic [7:0]    b_first;
        logic [7:0]    b_last;
        logic [AW-1:0] addr_end;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int st_edge;
        int i;
        u_if.start = 1'b0;
        u_if.len   = '0;
        fill(0);
        clear_logs();

        #12;
        check("reset tx", 64'(u_if.tx), 64'd1);
        check("reset busy", 64'(u_if.busy), 64'd0);
        check("reset done", 64'(u_if.done), 64'd0);
        check("reset rd_addr", 64'(u_if.rd_addr), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        vecs[0] = '{fill: 0, len: 1,  n_frames: 1,  b_first: 8'h41, b_last: 8'h41, addr_end: 6'd0};
        vecs[1] = '{fill: 1, len: 3,  n_frames: 3,  b_first: 8'h48, b_last: 8'h21, addr_end: 6'd2};
        vecs[2] = '{fill: 1, len: 0,  n_frames: 0,  b_first: 8'h00, b_last: 8'h00, addr_end: 6'd2};
        vecs[3] = '{fill: 2, len: 64, n_frames: 64, b_first: 8'h00, b_last: 8'h3F, addr_end: 6'd63};
        vecs[4] = '{fill: 2, len: 5,  n_frames: 5,  b_first: 8'h00, b_last: 8'h04, addr_end: 6'd4};

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].fill);
            clear_logs();
            pulse_start(vecs[v].len, st_edge);
            wait_done($sformatf("v%0d", v));
            repeat (5) @(negedge clk);
            check($sformatf("v%0d frames", v), 64'(rx_bytes.size()), 64'(vecs[v].n_frames));
            check($sformatf("v%0d done pulses", v), 64'(done_cnt), 64'd1);
            check($sformatf("v%0d done&busy", v), 64'(overlap_cnt), 64'd0);
            check($sformatf("v%0d rd_addr end", v), 64'(u_if.rd_addr), 64'(vecs[v].addr_end));
            if (vecs[v].len == 0) begin
                check($sformatf("v%0d busy seen", v), 64'(busy_seen), 64'd0);
                check($sformatf("v%0d tx low seen", v), 64'(low_seen), 64'd0);
                check($sformatf("v%0d done latency", v), 64'(done_cyc - st_edge), 64'd0);
            end else if (rx_bytes.size() == vecs[v].n_frames) begin
                check($sformatf("v%0d first byte", v), 64'(rx_bytes[0]), 64'(vecs[v].b_first));
                check($sformatf("v%0d last byte", v), 64'(rx_bytes[vecs[v].n_frames-1]),
                      64'(vecs[v].b_last));
                check($sformatf("v%0d frame shape", v), 64'(shape_err), 64'd0);
                check($sformatf("v%0d start latency", v), 64'(rx_start[0] - st_edge), 64'd2);
                check($sformatf("v%0d done after frame", v),
                      64'(done_cyc - rx_start[vecs[v].n_frames-1]), 64'(FrameCyc));
                for (int k = 0; k < vecs[v].n_frames; k++) begin
                    check($sformatf("v%0d byte%0d", v, k), 64'(rx_bytes[k]),
                          64'(fill_val(vecs[v].fill, k)));
                    check($sformatf("v%0d addr%0d", v, k), 64'(rx_addr[k]), 64'(k));
                    if (k > 0)
                        check($sformatf("v%0d gap%0d", v, k), 64'(rx_start[k] - rx_start[k-1]),
                              64'(FrameCyc + 2));
                end
            end
        end

        // Start pulsed again during data bits of byte 0 must be ignored
        fill(1);
        clear_logs();
        pulse_start(3, st_edge);
        for (i = 0; i < 200 && !(fpos >= 8 && rx_bytes.size() == 0); i++) @(negedge clk);
        check("restart reached data", 64'(i < 200), 64'd1);
        pulse_start(1, st_edge);
        wait_done("restart");
        repeat (5) @(negedge clk);
        check("restart frames", 64'(rx_bytes.size()), 64'd3);
        check("restart done pulses", 64'(done_cnt), 64'd1);
        if (rx_bytes.size() == 3) begin
            check("restart byte0", 64'(rx_bytes[0]), 64'h48);
            check("restart byte1", 64'(rx_bytes[1]), 64'h49);
            check("restart byte2", 64'(rx_bytes[2]), 64'h21);
        end

        // Reset during bit 4 of the first frame aborts it with the line high
        clear_logs();
        pulse_start(3, st_edge);
        for (i = 0; i < 200 && fpos < 21; i++) @(negedge clk);
        check("rst reached bit4", 64'(i < 200), 64'd1);
        #2;
        check("rst tx low in bit4", 64'(u_if.tx), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst tx high", 64'(u_if.tx), 64'd1);
        check("rst busy", 64'(u_if.busy), 64'd0);
        check("rst done", 64'(u_if.done), 64'd0);
        check("rst rd_addr", 64'(u_if.rd_addr), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst no done", 64'(done_cnt), 64'd0);
        check("rst no frame", 64'(rx_bytes.size()), 64'd0);
        clear_logs();
        pulse_start(2, st_edge);
        wait_done("post-rst");
        repeat (5) @(negedge clk);
        check("post-rst frames", 64'(rx_bytes.size()), 64'd2);
        if (rx_bytes.size() == 2) begin
            check("post-rst byte0", 64'(rx_bytes[0]), 64'h48);
            check("post-rst addr0", 64'(rx_addr[0]), 64'd0);
            check("post-rst byte1", 64'(rx_bytes[1]), 64'h49);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
